sevenseg_scan_ctrl: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 18 +
 rtl/sevenseg_scan_ctrl_hex7seg.sv | 33 +++
 rtl/sevenseg_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
// Optional leading-zero blanking in the controller is enabled by SEVENSEG_LZB_EN.
package sevenseg_pkg;

    // Each digit slot is an all-off BLANK interval followed by a DRIVE interval
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    // The Basys3 display is common-anode, so both busses are active-low
    localparam logic [6:0]            SEG_OFF = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;

endpackage

// File: rtl/sevenseg_scan_ctrl_hex7seg.sv
// Hex nibble to 7-segment decoder, active-high segments, seg[0]=A ... seg[6]=G.
module hex7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure lookup; the caller inverts for active-low panels
    always_comb begin
        seg = 7'h00;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// New values are taken via valid/ready into a shadow register and copied to the
// display register only when the scan wraps from digit 3 back to digit 0.
// Define SEVENSEG_LZB_EN to blank leading-zero digits (digit 0 is always shown).
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES   = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [15:0]           value_i,
    input  logic                  value_valid_i,
    output logic                  value_ready_o,
    input  logic [NUM_DIGITS-1:0] digit_en_i,
    output logic [NUM_DIGITS-1:0] anode_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o
);

    localparam int MAX_CYCLES = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;

    logic [15:0]       display;
    logic [15:0]       shadow;
    logic              pending;
    logic              wrap;
    logic              xfer;

    logic [3:0]            nibble;
    logic [6:0]            hex_seg;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] anode_next;
    logic [6:0]            seg_next;

    assign value_ready_o = ~pending;
    assign xfer          = value_valid_i & ~pending;
    assign dp_o          = 1'b1;

    // Slot sequencing: count through BLANK then DRIVE, advancing the digit after DRIVE
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        idx_next   = idx;
        wrap       = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                end
            end
            DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    idx_next   = idx + IDX_W'(1);
                    wrap       = (idx == IDX_LAST);
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
            end
        endcase
    end

    // Scan state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    // Handshake and frame-boundary apply; the two never coincide because a
    // transfer needs pending low while an apply needs it high
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            display <= 16'h0000;
            shadow  <= 16'h0000;
            pending <= 1'b0;
        end else if (wrap && pending) begin
            display <= shadow;
            pending <= 1'b0;
        end else if (xfer) begin
            shadow  <= value_i;
            pending <= 1'b1;
        end
    end

`ifdef SEVENSEG_LZB_EN
    // A digit above 0 is blanked when it and every digit above it are zero
    always_comb begin
        logic above_zero;
        lz_blank   = '0;
        above_zero = 1'b1;
        for (int n = NUM_DIGITS - 1; n > 0; n--) begin
            above_zero  = above_zero && (display[4*n +: 4] == 4'h0);
            lz_blank[n] = above_zero;
        end
    end
`else
    // Without blanking every enabled digit is shown, zeros included
    always_comb begin
        lz_blank = '0;
    end
`endif

    // One shared decoder fed with the currently scanned nibble
    always_comb begin
        nibble = display[4*idx +: 4];
    end

    hex7seg u_hex7seg (
        .hex (nibble),
        .seg (hex_seg)
    );

    // Output decode for the current slot; digit_en_i is used unlatched
    always_comb begin
        anode_next = AN_OFF;
        seg_next   = SEG_OFF;
        if (state == DRIVE) begin
            seg_next = ~hex_seg;
            if (digit_en_i[idx] && !lz_blank[idx]) begin
                anode_next[idx] = 1'b0;
            end
        end
    end

    // Registered outputs, one cycle behind the scan state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            anode_o <= AN_OFF;
            seg_o   <= SEG_OFF;
        end else begin
            anode_o <= anode_next;
            seg_o   <= seg_next;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Testbench for sevenseg_scan_ctrl with REFRESH_CYCLES=4, BLANK_CYCLES=2 (24-cycle frame).
// Expectations for leading-zero digits follow SEVENSEG_LZB_EN.
module tb_sevenseg_scan_ctrl;

    localparam int REFRESH = 4;
    localparam int BLANKC  = 2;

`ifdef SEVENSEG_LZB_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        value_valid;
    logic        value_ready;
    logic [3:0]  digit_en;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;

    sevenseg_scan_ctrl #(
        .REFRESH_CYCLES (REFRESH),
        .BLANK_CYCLES   (BLANKC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .value_i       (value),
        .value_valid_i (value_valid),
        .value_ready_o (value_ready),
        .digit_en_i    (digit_en),
        .anode_o       (anode),
        .seg_o         (seg),
        .dp_o          (dp)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // One record per checkpoint: outputs expected at that cycle, then inputs driven from it
    typedef struct {
        int          cyc;
        logic        rst;
        logic [3:0]  den;
        logic        vld;
        logic [15:0] val;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;
    int   cycle  = 0;

    function automatic vec_t mk(input int c, input logic r, input logic [3:0] d,
                                input logic vl, input logic [15:0] vv,
                                input logic [3:0] a, input logic [6:0] s, input logic rd);
        vec_t v;
        v.cyc = c;  v.rst = r;  v.den = d;  v.vld = vl;  v.val = vv;
        v.an  = a;  v.seg = s;  v.rdy = rd;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    endtask

    task automatic checkOutput(input vec_t v);
        checkValue("anode_o", {12'h0, anode}, {12'h0, v.an});
        checkValue("seg_o", {9'h0, seg}, {9'h0, v.seg});
        checkValue("value_ready_o", {15'h0, value_ready}, {15'h0, v.rdy});
        checkValue("dp_o", {15'h0, dp}, 16'h0001);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst         = v.rst;
        digit_en    = v.den;
        value_valid = v.vld;
        value       = v.val;
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Frame 0 (display 0000), handshake, ignored offer, apply at wrap
        vecs.push_back(mk(  0, 0, 4'hF, 0, 16'h0000, 4'hF, 7'h7F, 1));
        vecs.push_back(mk(  2, 0, 4'hF, 0, 16'h0000, 4'hF, 7'h7F, 1));
        vecs.push_back(mk(  3, 0, 4'hF, 0, 16'h0000, 4'hE, 7'h40, 1));
        vecs.push_back(mk(  5, 0, 4'hF, 1, 16'hA5C3, 4'hE, 7'h40, 1));
        vecs.push_back(mk(  6, 0, 4'hF, 1, 16'h1111, 4'hE, 7'h40, 0));
        vecs.push_back(mk(  7, 0, 4'hF, 1, 16'h1111, 4'hF, 7'h7F, 0));
        vecs.push_back(mk( 10, 0, 4'hF, 0, 16'h0000, LZB ? 4'hF : 4'hD, 7'h40, 0));
        vecs.push_back(mk( 23, 0, 4'hF, 0, 16'h0000, LZB ? 4'hF : 4'h7, 7'h40, 0));
        vecs.push_back(mk( 24, 0, 4'hF, 0, 16'h0000, LZB ? 4'hF : 4'h7, 7'h40, 1));
        // Frame 1 shows A5C3; digit 2 disabled from cycle 31
        vecs.push_back(mk( 25, 0, 4'hF, 0, 16'h0000, 4'hF, 7'h7F, 1));
        vecs.push_back(mk( 27, 0, 4'hF, 0, 16'h0000, 4'hE, 7'h30, 1));
        vecs.push_back(mk( 30, 0, 4'hF, 0, 16'h0000, 4'hE, 7'h30, 1));
        vecs.push_back(mk( 31, 0, 4'hB, 0, 16'h0000, 4'hF, 7'h7F, 1));
        vecs.push_back(mk( 33, 0, 4'hB, 0, 16'h0000, 4'hD, 7'h46, 1));
        vecs.push_back(mk( 39, 0, 4'hB, 0, 16'h0000, 4'hF, 7'h12, 1));
        vecs.push_back(mk( 42, 0, 4'hB, 0, 16'h0000, 4'hF, 7'h12, 1));
        vecs.push_back(mk( 43, 0, 4'hB, 0, 16'h0000, 4'hF, 7'h7F, 1));
        vecs.push_back(mk( 45, 0, 4'hB, 0, 16'h0000, 4'h7, 7'h08, 1));
        vecs.push_back(mk( 48, 0, 4'hF, 0, 16'h0000, 4'h7, 7'h08, 1));
        // Frame 2: length unchanged, mid-slot enable toggle on digit 0
        vecs.push_back(mk( 50, 0, 4'hF, 0, 16'h0000, 4'hF, 7'h7F, 1));
        vecs.push_back(mk( 51, 0, 4'hE, 0, 16'h0000, 4'hE, 7'h30, 1));
        vecs.push_back(mk( 52, 0, 4'hF, 0, 16'h0000, 4'hF, 7'h30, 1));
        vecs.push_back(mk( 53, 0, 4'hF, 0, 16'h0000, 4'hE, 7'h30, 1));
        // Pending value then reset during digit 1 DRIVE
        vecs.push_back(mk( 54, 0, 4'hF, 1, 16'h8888, 4'hE, 7'h30, 1));
        vecs.push_back(mk( 55, 0, 4'hF, 0, 16'h0000, 4'hF, 7'h7F, 0));
        vecs.push_back(mk( 57, 1, 4'hF, 0, 16'h0000, 4'hD, 7'h46, 0));
        vecs.push_back(mk( 58, 0, 4'hF, 0, 16'h0000, 4'hF, 7'h7F, 1));
        // Restarted timeline (release at 58): 0050 offered, leading-zero frame
        vecs.push_back(mk( 59, 0, 4'hF, 1, 16'h0050, 4'hF, 7'h7F, 1));
        vecs.push_back(mk( 60, 0, 4'hF, 0, 16'h0000, 4'hF, 7'h7F, 0));
        vecs.push_back(mk( 61, 0, 4'hF, 0, 16'h0000, 4'hE, 7'h40, 0));
        vecs.push_back(mk( 81, 0, 4'hF, 0, 16'h0000, LZB ? 4'hF : 4'h7, 7'h40, 0));
        vecs.push_back(mk( 82, 0, 4'hF, 0, 16'h0000, LZB ? 4'hF : 4'h7, 7'h40, 1));
        vecs.push_back(mk( 85, 0, 4'hF, 0, 16'h0000, 4'hE, 7'h40, 1));
        vecs.push_back(mk( 91, 0, 4'hF, 0, 16'h0000, 4'hD, 7'h12, 1));
        vecs.push_back(mk( 97, 0, 4'hF, 0, 16'h0000, LZB ? 4'hF : 4'hB, 7'h40, 1));
        vecs.push_back(mk(103, 0, 4'hF, 0, 16'h0000, LZB ? 4'hF : 4'h7, 7'h40, 1));

        // Hold reset three cycles and check the reset-time outputs
        rst         = 1'b1;
        digit_en    = 4'hF;
        value_valid = 1'b0;
        value       = 16'h0000;
        repeat (3) tick();
        checkValue("reset anode_o", {12'h0, anode}, 16'h000F);
        checkValue("reset seg_o", {9'h0, seg}, 16'h007F);
        checkValue("reset value_ready_o", {15'h0, value_ready}, 16'h0001);
        checkValue("reset dp_o", {15'h0, dp}, 16'h0001);

        $display("[TB] releasing reset, %0d vectors", vecs.size());
        rst   = 1'b0;
        cycle = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            int guard = 0;
            while (cycle < vecs[i].cyc && guard < 1000) begin
                tick();
                guard++;
            end
            if (cycle != vecs[i].cyc) begin
                checks++;
                $display("[TB] FAIL vector order at index %0d: cycle %0d, wanted %0d", i, cycle, vecs[i].cyc);
            end
            checkOutput(vecs[i]);
            applyStimulus(vecs[i]);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
